pll_lock_supervisor: RTL

//  Supervises the 25 MHz -> 37.5 MHz PLL: drives the PLL reset, consumes its locked output,
//  and issues a qualified pll_ready to downstream 37.5 MHz logic only after lock has been stable.

---
 rtl/pll_lock_supervisor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the 25 MHz reference: sequences the PLL reset, qualifies lock,
// retries on timeout, latches a fault after repeated failures and counts lock losses.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 25000,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk_i,
  input  logic             rst_ni,
  input  logic             pll_locked_i,
  input  logic             retry_req_i,
  output logic             pll_rst_o,
  output logic             pll_ready_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned TMR_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > RST_CYCLES) ? TMR_MAX_A : RST_CYCLES;
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned RTY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  // The locked sample that moved us out of WAIT_LOCK is the first of the qualifying run.
  localparam logic [TMR_W-1:0] STB_LAST  = (STABLE_CYCLES > 1) ? TMR_W'(STABLE_CYCLES - 2) : '0;
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retries_q, retries_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               sync1_q, sync2_q;
  logic               pll_rst_q, pll_rst_d;
  logic               pll_ready_q, pll_ready_d;
  logic               fault_q, fault_d;
  logic               locked_s;

  assign locked_s = sync2_q;

  // State, timers, synchronizer and registered outputs.
  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RESET;
      timer_q     <= '0;
      retries_q   <= '0;
      loss_cnt_q  <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retries_q   <= retries_d;
      loss_cnt_q  <= loss_cnt_d;
      sync1_q     <= pll_locked_i;
      sync2_q     <= sync1_q;
      pll_rst_q   <= pll_rst_d;
      pll_ready_q <= pll_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state, retry/loss bookkeeping and output decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retries_d  = retries_q;
    loss_cnt_d = loss_cnt_q;

    if (retry_req_i) begin
      state_d   = ST_RESET;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
          else                     state_d = ST_RESET;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
          end else if (timer_q == TMO_LAST) begin
            retries_d = retries_q + RTY_W'(1);
            if (retries_d == RTY_LIMIT) state_d = ST_FAULT;
            else                        state_d = ST_RESET;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STB_LAST) begin
            state_d   = ST_READY;
            retries_d = '0;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            state_d = ST_RESET;
            if (loss_cnt_q != CNT_SAT) loss_cnt_d = loss_cnt_q + CNT_W'(1);
            else                       loss_cnt_d = loss_cnt_q;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RESET;
      endcase
    end

    if (retry_req_i || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == ST_READY) || (state_q == ST_FAULT)) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
    pll_ready_d = (state_d == ST_READY);
    fault_d     = (state_d == ST_FAULT);
  end

  assign pll_rst_o       = pll_rst_q;
  assign pll_ready_o     = pll_ready_q;
  assign fault_o         = fault_q;
  assign lock_loss_cnt_o = loss_cnt_q;
  assign state_o         = state_q;

endmodule
